// File: rtl/lc2k_pkg.sv
// ============================================================================
// Module  : lc2k_pkg
// Brief   : Shared widths, writeback-select encodings and writeback entry type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc2k_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC1  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/lc2k_regfile_wb_if.sv
// ============================================================================
// Module  : lc2k_regfile_wb_if
// Brief   : Control, write-data and read-port bundle of the register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface lc2k_regfile_wb_if;
    import lc2k_pkg::*;

    logic                 CONTROL_regWrite;
    logic [1:0]           CONTROL_wbSel;
    logic                 CONTROL_stall;
    logic [REG_IDX_W-1:0] destReg;
    logic [DATA_W-1:0]    aluResult;
    logic [DATA_W-1:0]    memData;
    logic [DATA_W-1:0]    pcPlusOne;
    logic [REG_IDX_W-1:0] regA;
    logic [REG_IDX_W-1:0] regB;
    logic [DATA_W-1:0]    regAvalue;
    logic [DATA_W-1:0]    regBvalue;
    logic                 wbPending;
    logic [DATA_W-1:0]    commitCount;

    modport master (
        output CONTROL_regWrite, CONTROL_wbSel, CONTROL_stall, destReg,
        output aluResult, memData, pcPlusOne, regA, regB,
        input  regAvalue, regBvalue, wbPending, commitCount
    );

    modport slave (
        input  CONTROL_regWrite, CONTROL_wbSel, CONTROL_stall, destReg,
        input  aluResult, memData, pcPlusOne, regA, regB,
        output regAvalue, regBvalue, wbPending, commitCount
    );

endinterface

`default_nettype wire

// File: rtl/lc2k_wb_data_mux.sv
// ============================================================================
// Module  : lc2k_wb_data_mux
// Brief   : Selects the writeback data source; the reserved code yields zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc2k_wb_data_mux
    import lc2k_pkg::*;
(
    input  wire logic [1:0]        i_wb_sel,
    input  wire logic [DATA_W-1:0] i_alu_result,
    input  wire logic [DATA_W-1:0] i_mem_data,
    input  wire logic [DATA_W-1:0] i_pc_plus_one,
    output logic      [DATA_W-1:0] o_wb_data
);

    always_comb begin
        o_wb_data = '0;
        unique case (wb_sel_e'(i_wb_sel))
            WB_ALU:  o_wb_data = i_alu_result;
            WB_MEM:  o_wb_data = i_mem_data;
            WB_PC1:  o_wb_data = i_pc_plus_one;
            default: o_wb_data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lc2k_regfile_wb.sv
// ============================================================================
// Module  : lc2k_regfile_wb
// Brief   : 8x32 register file with a one-entry writeback stage, read bypass
//           and a committed-write counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc2k_regfile_wb
    import lc2k_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          reset,
    lc2k_regfile_wb_if.slave   bus
);

    logic [DATA_W-1:0] w_wb_data;

    wb_entry_t         wb_q, wb_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
    logic [DATA_W-1:0] commit_count_q, commit_count_d;

    lc2k_wb_data_mux u_wb_data_mux (
        .i_wb_sel      (bus.CONTROL_wbSel),
        .i_alu_result  (bus.aluResult),
        .i_mem_data    (bus.memData),
        .i_pc_plus_one (bus.pcPlusOne),
        .o_wb_data     (w_wb_data)
    );

    // Capture and commit share one edge; a stall freezes the whole stage.
    always_comb begin
        wb_d           = wb_q;
        rf_d           = rf_q;
        commit_count_d = commit_count_q;
        if (!bus.CONTROL_stall) begin
            wb_d.valid = bus.CONTROL_regWrite;
            wb_d.dest  = bus.destReg;
            wb_d.data  = w_wb_data;
            if (wb_q.valid && (wb_q.dest != '0)) begin
                rf_d[wb_q.dest] = wb_q.data;
                commit_count_d  = commit_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q           <= '0;
            commit_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wb_q           <= wb_d;
            commit_count_q <= commit_count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Pending entry shadows the array so a consumer sees the youngest value.
    always_comb begin
        bus.regAvalue = rf_q[bus.regA];
        if (bus.regA == '0) begin
            bus.regAvalue = '0;
        end else if (wb_q.valid && (wb_q.dest == bus.regA)) begin
            bus.regAvalue = wb_q.data;
        end
    end

    always_comb begin
        bus.regBvalue = rf_q[bus.regB];
        if (bus.regB == '0) begin
            bus.regBvalue = '0;
        end else if (wb_q.valid && (wb_q.dest == bus.regB)) begin
            bus.regBvalue = wb_q.data;
        end
    end

    assign bus.wbPending   = wb_q.valid;
    assign bus.commitCount = commit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_lc2k_regfile_wb.sv
// ============================================================================
// Module  : tb_lc2k_regfile_wb
// Brief   : Scoreboard bench: driver pushes model predictions, monitor compares.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lc2k_regfile_wb;

    logic clk;
    logic reset;

    lc2k_regfile_wb_if bus ();

    lc2k_regfile_wb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned a_idx;
        int unsigned b_idx;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_pend;
        logic [31:0] exp_cnt;
        logic [31:0] exp_arr_b;
    } exp_t;

    typedef struct {
        int unsigned dest;
        logic [31:0] data;
    } pend_t;

    exp_t        sb_q[$];
    pend_t       m_pend[$];
    logic [31:0] m_rf[8];
    logic [31:0] m_cnt;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int unsigned idx);
        if (idx == 0) return 32'd0;
        for (int i = m_pend.size() - 1; i >= 0; i--) begin
            if (m_pend[i].dest == idx) return m_pend[i].data;
        end
        return m_rf[idx];
    endfunction

    task automatic m_reset();
        m_pend.delete();
        m_cnt = 32'd0;
        for (int i = 0; i < 8; i++) m_rf[i] = 32'd0;
    endtask

    // Called at posedge+1; the monitor checks at the following negedge.
    task automatic step(input logic rw, input logic [1:0] sel, input int unsigned dest,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc1,
                        input logic stall, input int unsigned ra, input int unsigned rb);
        exp_t        e;
        pend_t       p;
        logic [31:0] wd;
        bus.CONTROL_regWrite = rw;
        bus.CONTROL_wbSel    = sel;
        bus.CONTROL_stall    = stall;
        bus.destReg          = dest[2:0];
        bus.aluResult        = alu;
        bus.memData          = mem;
        bus.pcPlusOne        = pc1;
        bus.regA             = ra[2:0];
        bus.regB             = rb[2:0];
        e.a_idx     = ra;
        e.b_idx     = rb;
        e.exp_a     = m_read(ra);
        e.exp_b     = m_read(rb);
        e.exp_pend  = (m_pend.size() != 0);
        e.exp_cnt   = m_cnt;
        e.exp_arr_b = m_rf[rb];
        sb_q.push_back(e);
        wd = (sel == 2'd0) ? alu : (sel == 2'd1) ? mem : (sel == 2'd2) ? pc1 : 32'd0;
        if (!stall) begin
            if (m_pend.size() != 0) begin
                p = m_pend.pop_front();
                if (p.dest != 0) begin
                    m_rf[p.dest] = p.data;
                    m_cnt        = m_cnt + 32'd1;
                end
            end
            if (rw) begin
                p.dest = dest;
                p.data = wd;
                m_pend.push_back(p);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned ra, input int unsigned rb);
        step(1'b0, 2'd0, 0, 32'd0, 32'd0, 32'd0, 1'b0, ra, rb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("regAvalue", bus.regAvalue, e.exp_a);
                check("regBvalue", bus.regBvalue, e.exp_b);
                check("wbPending", {31'd0, bus.wbPending}, {31'd0, e.exp_pend});
                check("commitCount", bus.commitCount, e.exp_cnt);
                check("array_regB", dut.rf_q[e.b_idx], e.exp_arr_b);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 1'b1;
        bus.CONTROL_regWrite = 1'b0;
        bus.CONTROL_wbSel    = 2'd0;
        bus.CONTROL_stall    = 1'b0;
        bus.destReg          = 3'd0;
        bus.aluResult        = 32'd0;
        bus.memData          = 32'd0;
        bus.pcPlusOne        = 32'd0;
        bus.regA             = 3'd1;
        bus.regB             = 3'd7;
        m_reset();
        n_checks = 0;
        n_fail   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wbPending", {31'd0, bus.wbPending}, 32'd0);
        check("reset_commitCount", bus.commitCount, 32'd0);
        check("reset_regA", bus.regAvalue, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // write reg3 via ALU, bypass then array
        step(1'b1, 2'd0, 3, 32'h0000_1234, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, 0);
        idle(0, 3);
        idle(0, 3);
        // reg0 writes are dropped
        step(1'b1, 2'd1, 0, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0);
        idle(0, 3);
        idle(0, 3);
        // back-to-back writes to reg5
        step(1'b1, 2'd2, 5, 32'h5, 32'h6, 32'h10, 1'b0, 5, 5);
        step(1'b1, 2'd1, 5, 32'h7, 32'h20, 32'h8, 1'b0, 5, 5);
        idle(5, 5);
        idle(5, 5);
        // reserved select captures zero
        step(1'b1, 2'd3, 6, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 1'b0, 6, 6);
        idle(6, 6);
        idle(6, 6);
        // stall holds a pending write to reg2
        step(1'b1, 2'd0, 2, 32'd7, 32'd0, 32'd0, 1'b0, 2, 2);
        repeat (3) step(1'b1, 2'd0, 2, 32'h99, 32'h98, 32'h97, 1'b1, 2, 2);
        idle(2, 2);
        idle(2, 2);

        // counter wrap
        force dut.commit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_count_q;
        m_cnt = 32'hFFFF_FFFF;
        step(1'b1, 2'd0, 1, 32'h55, 32'd0, 32'd0, 1'b0, 1, 1);
        idle(1, 1);
        idle(1, 1);

        // reset mid-cycle with a pending write to reg4
        step(1'b1, 2'd0, 4, 32'h4444, 32'd0, 32'd0, 1'b0, 4, 4);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_wbPending", {31'd0, bus.wbPending}, 32'd0);
        check("midreset_commitCount", bus.commitCount, 32'd0);
        check("midreset_regA", bus.regAvalue, 32'd0);
        check("midreset_array_reg1", dut.rf_q[1], 32'd0);
        m_reset();
        bus.CONTROL_regWrite = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4, 4);
        idle(4, 4);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 7),
                 $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end
        idle(1, 2);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lc2k_regfile_wb.md
LC2K_REGFILE_WB -- requirements
Module: lc2k_regfile_wb

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL: CONTROL_regWrite  in  1  current instruction writes a register.
REQ-004 SHALL: CONTROL_wbSel  in  2  write-data select: 0 aluResult, 1 memData, 2 pcPlusOne; 3 reserved.
REQ-005 SHALL: CONTROL_stall  in  1  holds the writeback register; no capture, no commit.
REQ-006 SHALL: destReg  in  3  destination register index.
REQ-007 SHALL: aluResult, memData, pcPlusOne  in  32 each  candidate write data.
REQ-008 SHALL: regA, regB  in  3 each  read indices.
REQ-009 SHALL: regAvalue, regBvalue  out  32 each  read data; regBvalue feeds ALU operand-B select.
REQ-010 SHALL: wbPending  out  1  writeback register holds an uncommitted write.
REQ-011 SHALL: commitCount  out  32  number of committed register writes.

Function
REQ-012 SHALL: state = 8 x 32-bit registers, one writeback register {valid, dest[2:0], data[31:0]}, one 32-bit commit counter.
REQ-013 SHALL: in cycle N with CONTROL_stall=0, the writeback register captures valid=CONTROL_regWrite, dest=destReg, data=mux(CONTROL_wbSel).
REQ-014 SHALL: in that same edge, a previously valid writeback register entry commits to the register file; write latency is therefore two edges from input presentation to array update.
REQ-015 SHALL: CONTROL_wbSel=3 with CONTROL_regWrite=1 capture data 0.
REQ-016 SHALL: writes to register 0 are discarded and not counted; register 0 always reads 0.
REQ-017 SHALL: reads are combinational; when the writeback register is valid, dest matches the read index, and the index is non-zero, the read returns the pending data (bypass), otherwise the array value.
REQ-018 SHALL: with CONTROL_stall=1, the writeback register and the array hold, and no commit occurs; bypass still applies.
REQ-019 SHALL: commitCount increments by 1 on each committed non-zero-destination write; it wraps from 0xFFFFFFFF to 0.
REQ-020 SHALL: wbPending equals the writeback register valid bit.
REQ-021 SHALL: back-to-back writes to the same register commit in order; the read value tracks the younger pending entry.

Reset
REQ-022 SHALL: reset asserted clears all 8 registers, writeback valid, dest, data, and commitCount to 0 immediately, independent of clk.
REQ-023 SHALL: a pending write present when reset asserts is lost and never committed.
REQ-024 SHALL: after reset deasserts, the first capture occurs on the first rising edge with CONTROL_stall=0.

Structure
REQ-025 SHALL: a shared package lc2k_pkg holds the wbSel encodings (WB_ALU=0, WB_MEM=1, WB_PC1=2), NUM_REGS=8, REG_IDX_W=3, and DATA_W=32.
REQ-026 SHALL: the write-data select is a sub-module lc2k_wb_data_mux; the array, writeback register, bypass, and counter are in the top module.

Verification
REQ-027 SHALL: write reg3 via aluResult=0x0000_1234, then read regB=3 on the next cycle -> 0x1234 via bypass; after a second edge, 0x1234 from the array; commitCount=1.
REQ-028 SHALL: write reg0 with memData=0xDEAD_BEEF -> regAvalue(0)=0 throughout; commitCount unchanged.
REQ-029 SHALL: write reg5=pcPlusOne 0x10, then reg5=memData 0x20 on consecutive cycles -> reads 0x10 then 0x20; final array reg5=0x20; commitCount=2.
REQ-030 SHALL: capture a write to reg2=7, then hold CONTROL_stall=1 for 3 cycles -> wbPending=1, array reg2=0, bypass read=7; after stall release and one edge, array reg2=7.
REQ-031 SHALL: assert reset mid-cycle while a write to reg4 is pending -> outputs clear immediately, wbPending=0, reg4 reads 0 after release.
REQ-032 SHALL: preload commitCount near 0xFFFFFFFF by forcing, or commit until it reaches that value, then commit once more -> commitCount wraps to 0.
